// File: rtl/mem_responder_pkg.sv
// Shared constants for the memory responder: FSM encodings, byte-lane geometry
// and the stall LFSR used when MEM_RESPONDER_STALL_EN is defined.
package mem_responder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int LANE_W  = 8;
  localparam int N_LANES = 4;

  // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mem_byte_ram.sv
// Single-port DEPTH_WORDS x 32 RAM with per-byte write enables and a registered
// read-first output; contents are not reset.
module mem_byte_ram
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                      clk,
  input  logic [AW-1:0]             addr,
  input  logic [N_LANES-1:0]        we,
  input  logic [N_LANES*LANE_W-1:0] wdata,
  output logic [N_LANES*LANE_W-1:0] rdata
);

  logic [N_LANES*LANE_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    rdata <= mem[addr];
    for (int i = 0; i < N_LANES; i++) begin
      if (we[i]) mem[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Valid/ready memory responder with fixed access latency in front of a byte-laned
// word RAM. Defining MEM_RESPONDER_STALL_EN adds 0-3 pseudo-random wait cycles.
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | counting down latency; access happens when the counter is 0
// RESP  | response held until resp_ready
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_we,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY + 4);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] load_cnt;
  logic [AW-1:0] idx_q;
  logic [3:0]    we_q;
  logic [31:0]   wdata_q;
  logic          err_q;
  logic [31:0]   word_off;
  logic          req_err;
  logic          accept;
  logic          access;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_we;
  logic [31:0]   ram_rdata;

  assign req_ready  = (state == ST_IDLE) && !reset;
  assign resp_valid = (state == ST_RESP);
  assign accept     = req_valid && req_ready;
  assign access     = (state == ST_WAIT) && (cnt == '0);

  assign word_off = (req_addr - BASE_ADDR) >> 2;
  assign req_err  = (req_addr[1:0] != 2'b00) || (req_addr < BASE_ADDR) ||
                    (word_off >= 32'(DEPTH_WORDS));

  // Present the incoming address while idle so read data is ready even at LATENCY 0
  assign ram_addr = (state == ST_IDLE) ? word_off[AW-1:0] : idx_q;
  assign ram_we   = (access && !err_q && !reset) ? we_q : 4'b0000;

`ifdef MEM_RESPONDER_STALL_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk) begin
    if (reset) lfsr <= LFSR_SEED;
    else if (accept) lfsr <= lfsr_next(lfsr);
  end

  assign load_cnt = CW'(LATENCY) + CW'(lfsr[1:0]);
`else
  assign load_cnt = CW'(LATENCY);
`endif

  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q   <= word_off[AW-1:0];
      we_q    <= req_we;
      wdata_q <= req_wdata;
      err_q   <= req_err;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state <= ST_WAIT;
            cnt   <= load_cnt;
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            state      <= ST_RESP;
            resp_err   <= err_q;
            resp_rdata <= (err_q || (we_q != 4'b0000)) ? '0 : ram_rdata;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (resp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  mem_byte_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk  (clk),
    .addr (ram_addr),
    .we   (ram_we),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Memory-side responder for the core's load/store path, replacing the combinational data memory once the core issues requests over a valid/ready handshake.
- Accepts one word-addressed request at a time with byte-lane write enables.
- Models a fixed access latency.
- Returns read data or an error through a separate response channel held until accepted.
- Sits between the core's LSU request port and a byte-laned word RAM.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words; power of two
LATENCY, 2, wait cycles between request acceptance and response valid; 0 allowed
BASE_ADDR, 32'h0000_0000, byte address of word 0

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_addr  input  32  byte address
req_we  input  4  byte-lane write enables; nonzero = write, zero = read
req_wdata  input  32  write data, lane i = bits 8i+7:8i
resp_valid  output  1  response present
resp_ready  input  1  core accepts response
resp_rdata  output  32  read data; 0 for writes and errors
resp_err  output  1  misaligned or out-of-range access

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high. All state updates on posedge clk.
- Reset values:
  - state = IDLE, resp_valid = 0, resp_rdata = 0, resp_err = 0, latency counter = 0.
  - req_ready = 0 in any cycle where reset is high.
  - RAM contents are not reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready, latch addr/we/wdata and load counter = LATENCY.
  - Go to WAIT if LATENCY > 0, else to ACCESS-in-WAIT with counter 0.
- WAIT:
  - req_ready = 0; counter decrements each cycle.
  - In the cycle the counter is 0, perform the access:
    - Write: update only enabled lanes.
    - Read: capture the full word.
  - Then go to RESP with resp_valid = 1.
  - Accept-to-resp_valid latency is exactly LATENCY+1 cycles.
- RESP:
  - resp_valid = 1; resp_rdata and resp_err are held stable until resp_ready.
  - On resp_valid && resp_ready, go to IDLE.
  - req_ready rises the next cycle; there is no same-cycle re-accept.
  - Peak throughput is one transaction per LATENCY+3 cycles when resp_ready is held high.
- Error cases: addr[1:0] != 0, or (addr-BASE_ADDR)>>2 >= DEPTH_WORDS, or addr < BASE_ADDR.
  - resp_err = 1, resp_rdata = 0, no RAM write.
  - Same latency as a good access.
- Write response: resp_rdata = 0, resp_err = 0.
- Word index = (addr - BASE_ADDR) >> 2, truncated to log2(DEPTH_WORDS) bits after the range check.
- Request inputs are ignored outside IDLE.
- req_valid deasserting before acceptance is legal.
- Reset asserted mid-transaction:
  - Abandon the transaction; next state is IDLE with no pending response.
  - A write whose access cycle coincides with reset is not performed.
- req_we = 4'b0000 with req_valid is a read.

Optional Feature:
MEM_RESPONDER_STALL_EN
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5 on reset) advances once per accepted request.
  - Its low 2 bits add 0–3 extra WAIT cycles to that transaction.
  - Used to stress the core's handshake.
- Undefined:
  - Latency is exactly LATENCY+1; no LFSR logic is present.

Decomposition:
- Package mem_responder_pkg:
  - State enum (IDLE, WAIT, RESP).
  - Lane width constant 8 and lane count 4.
  - LFSR seed and taps constants.
- Sub-module mem_byte_ram:
  - Synchronous DEPTH_WORDS x 32 RAM with 4 lane write enables and registered read.
  - The responder FSM, counter, address check and response registers stay in mem_responder.

Test Plan:
1. Reset 3 cycles, release -> req_ready = 1 next cycle; resp_valid = 0.
2. Write addr 0x10, we 4'b1111, wdata 0xDEADBEEF, then read 0x10 with LATENCY = 2 -> resp_valid exactly 3 cycles after each accept; read resp_rdata = 0xDEADBEEF, resp_err = 0.
3. Write 0x10 with we 4'b0010, wdata 0x0000_5500 over 0xDEADBEEF -> subsequent read returns 0xDEAD55EF.
4. Read addr 0x13 and read addr 4*DEPTH_WORDS -> resp_err = 1, resp_rdata = 0; a following write to 4*DEPTH_WORDS leaves word 0 unchanged.
5. Hold resp_ready = 0 for 5 cycles in RESP -> resp_valid, resp_rdata and resp_err stable; req_ready = 0; new req_valid is not accepted until the cycle after resp_ready.
6. Assert reset during WAIT of a write to 0x20 (prior value 0x11111111) -> no response appears; a later read of 0x20 returns 0x11111111.
